// File: rtl/lfsr15_check_if.sv
// Word stream and status bundle for the 15-bit LFSR pattern checker.
// Carries bit_count only when LFSR15_CHECK_BITCNT_EN is defined.
interface lfsr15_check_if #(
    parameter int DataBits  = 32,
    parameter int CountBits = 32
);
    localparam int EbW = $clog2(DataBits + 1);

    logic                 clear;
    logic                 data_valid;
    logic [DataBits-1:0]  data;
    logic                 locked;
    logic                 err_pulse;
    logic [EbW-1:0]       err_bits;
    logic [CountBits-1:0] err_count;
`ifdef LFSR15_CHECK_BITCNT_EN
    logic [47:0]          bit_count;
`endif

    modport master (
        output clear,
        output data_valid,
        output data,
        input  locked,
        input  err_pulse,
        input  err_bits,
`ifdef LFSR15_CHECK_BITCNT_EN
        input  bit_count,
`endif
        input  err_count
    );

    modport slave (
        input  clear,
        input  data_valid,
        input  data,
        output locked,
        output err_pulse,
        output err_bits,
`ifdef LFSR15_CHECK_BITCNT_EN
        output bit_count,
`endif
        output err_count
    );
endinterface

// File: rtl/lfsr15_check.sv
// Self-synchronising checker for the x^15+x^14+1 LFSR pattern.
// Define LFSR15_CHECK_BITCNT_EN to add the 48-bit locked bit counter.
module lfsr15_check #(
    parameter int DataBits    = 32,
    parameter int CountBits   = 32,
    parameter int LockWords   = 4,
    parameter int UnlockWords = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    lfsr15_check_if.slave  bus
);
    localparam int EbW = $clog2(DataBits + 1);
    localparam int XW  = DataBits + 15;
    localparam int GW  = $clog2(LockWords + 1);
    localparam int BW  = $clog2(UnlockWords + 1);
    localparam int SW  = ((CountBits > EbW) ? CountBits : EbW) + 1;

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    // b[0..14] = s, b[i] = b[i-15] ^ b[i-14] up to DataBits+15 bits
    function automatic logic [XW-1:0] extend(input logic [14:0] s);
        logic [XW-1:0] b;
        b = '0;
        b[14:0] = s;
        for (int i = 15; i < XW; i++)
            b[i] = b[i-15] ^ b[i-14];
        return b;
    endfunction

    function automatic logic [14:0] next15(input logic [14:0] s);
        logic [29:0] b;
        b = '0;
        b[14:0] = s;
        for (int i = 15; i < 30; i++)
            b[i] = b[i-15] ^ b[i-14];
        return b[29:15];
    endfunction

    function automatic logic [EbW-1:0] popcount(
        input logic [DataBits-1:0] x
    );
        logic [EbW-1:0] c;
        c = '0;
        for (int i = 0; i < DataBits; i++)
            c = c + EbW'(x[i]);
        return c;
    endfunction

    state_t               state;
    logic [14:0]          lfsr;
    logic                 seeded;
    logic [GW-1:0]        good_cnt;
    logic [BW-1:0]        bad_cnt;
    logic                 err_pulse;
    logic [EbW-1:0]       err_bits;
    logic [CountBits-1:0] err_count;

    logic [XW-1:0]        ext;
    logic [DataBits-1:0]  expected;
    logic [14:0]          advance;
    logic [14:0]          reseed;
    logic [DataBits-1:0]  err;
    logic [EbW-1:0]       nerr;
    logic [GW-1:0]        good_next;
    logic [BW-1:0]        bad_next;
    logic [SW-1:0]        sum;
    logic [CountBits-1:0] count_sat;

    always_comb begin
        ext       = extend(lfsr);
        expected  = ext[DataBits-1:0];
        advance   = ext[XW-1:DataBits];
        reseed    = next15(bus.data[DataBits-1 -: 15]);
        err       = bus.data ^ expected;
        nerr      = popcount(err);
        good_next = '0;
        if (seeded && err == '0)
            good_next = good_cnt + 1'b1;
        bad_next = '0;
        if (err != '0)
            bad_next = bad_cnt + 1'b1;
        sum = SW'(err_count) + SW'(nerr);
        count_sat = sum[CountBits-1:0];
        if (sum[SW-1:CountBits] != '0)
            count_sat = '1;
    end

`ifdef LFSR15_CHECK_BITCNT_EN
    logic [47:0] bit_count;
    logic [48:0] bit_sum;

    always_comb begin
        bit_sum = {1'b0, bit_count} + 49'(DataBits);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count <= '0;
        end else if (bus.clear) begin
            bit_count <= '0;
        end else if (bus.data_valid && state == LOCKED) begin
            bit_count <= bit_sum[48] ? '1 : bit_sum[47:0];
        end
    end

    assign bus.bit_count = bit_count;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            lfsr      <= '0;
            seeded    <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            err_pulse <= 1'b0;
            err_bits  <= '0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (bus.clear)
                err_count <= '0;
            if (bus.data_valid) begin
                err_bits <= nerr;
                unique case (state)
                    SEARCH: begin
                        lfsr   <= reseed;
                        seeded <= 1'b1;
                        if (good_next == GW'(LockWords)) begin
                            state    <= LOCKED;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            good_cnt <= good_next;
                        end
                    end
                    LOCKED: begin
                        // free-run on own prediction so bad data never reseeds
                        lfsr      <= advance;
                        err_pulse <= (err != '0);
                        if (!bus.clear)
                            err_count <= count_sat;
                        if (bad_next == BW'(UnlockWords)) begin
                            state    <= SEARCH;
                            bad_cnt  <= '0;
                            good_cnt <= '0;
                            seeded   <= 1'b0;
                        end else begin
                            bad_cnt <= bad_next;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.locked    = (state == LOCKED);
    assign bus.err_pulse = err_pulse;
    assign bus.err_bits  = err_bits;
    assign bus.err_count = err_count;
endmodule

// File: tb/tb_lfsr15_check.sv
// Scoreboard bench for lfsr15_check: 32-bit counter DUT plus a 4-bit
// counter DUT sharing one stimulus stream.
module tb_lfsr15_check;
    logic clk;
    logic rst_n;

    lfsr15_check_if #(.DataBits(32), .CountBits(32)) ifc ();
    lfsr15_check_if #(.DataBits(32), .CountBits(4))  ifc4 ();

    assign ifc4.clear      = ifc.clear;
    assign ifc4.data_valid = ifc.data_valid;
    assign ifc4.data       = ifc.data;

    lfsr15_check #(
        .DataBits(32), .CountBits(32), .LockWords(4), .UnlockWords(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
    );

    lfsr15_check #(
        .DataBits(32), .CountBits(4), .LockWords(4), .UnlockWords(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(ifc4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit lk;
        bit pl;
        int bits;
        int cnt;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [14:0] gw = 15'h5555;

    function automatic void chk(string nm, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s act=%0d exp=%0d @%0t", nm, act, exp, $time);
        end
    endfunction

    task automatic gen(output logic [31:0] w);
        for (int j = 0; j < 32; j++) begin
            w[j] = gw[0];
            gw = {gw[0] ^ gw[1], gw[14:1]};
        end
    endtask

    task automatic drive(input logic [31:0] w, input bit v, input bit clr,
                         input exp_t e);
        @(negedge clk);
        ifc.data       = w;
        ifc.data_valid = v;
        ifc.clear      = clr;
        if (v)
            sb.push_back(e);
    endtask

    task automatic word(input logic [31:0] flip, input bit clr, input bit lk,
                        input bit pl, input int bits, input int cnt);
        logic [31:0] w;
        exp_t e;
        gen(w);
        e.lk = lk; e.pl = pl; e.bits = bits; e.cnt = cnt;
        drive(w ^ flip, 1'b1, clr, e);
    endtask

    task automatic idle();
        exp_t e;
        e.lk = 0; e.pl = 0; e.bits = -1; e.cnt = 0;
        drive($urandom, 1'b0, 1'b0, e);
    endtask

    always @(posedge clk) begin
        bit   v;
        exp_t e;
        v = ifc.data_valid;
        #1;
        if (v) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("locked", ifc.locked, e.lk);
                chk("err_pulse", ifc.err_pulse, e.pl);
                if (e.bits >= 0)
                    chk("err_bits", ifc.err_bits, e.bits);
                chk("err_count", ifc.err_count, e.cnt);
                chk("locked4", ifc4.locked, e.lk);
                chk("err_count4", ifc4.err_count,
                    (e.cnt > 15) ? 15 : e.cnt);
            end
        end else begin
            chk("idle_pulse", ifc.err_pulse, 0);
            chk("idle_pulse4", ifc4.err_pulse, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int vcnt;
        rst_n          = 1'b0;
        ifc.clear      = 1'b0;
        ifc.data_valid = 1'b0;
        ifc.data       = '0;
        #7;
        chk("rst_locked", ifc.locked, 0);
        chk("rst_pulse", ifc.err_pulse, 0);
        chk("rst_bits", ifc.err_bits, 0);
        chk("rst_count", ifc.err_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // clean stream: seed word, then lock after word 5
        for (int k = 1; k <= 1000; k++)
            word(0, 0, k >= 5, 0, (k == 1) ? -1 : 0, 0);

        word(32'h8, 0, 1, 1, 1, 1);
        word(0, 0, 1, 0, 0, 1);
        word(32'hFFFF_FFFF, 0, 1, 1, 32, 33);
        word(0, 0, 1, 0, 0, 33);

        // three bad words then a good one keeps lock
        cnt = 33;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) begin
                cnt++;
                word(32'h1, 0, 1, 1, 1, cnt);
            end
            word(0, 0, 1, 0, 0, cnt);
        end
        for (int i = 0; i < 4; i++) begin
            cnt++;
            word(32'h1, 0, i < 3, 1, 1, cnt);
        end
        word(0, 0, 0, 0, -1, cnt);
        for (int i = 1; i <= 4; i++)
            word(0, 0, i == 4, 0, 0, cnt);
        word(0, 0, 1, 0, 0, cnt);

        // clear, then saturate the 4-bit counter
        word(0, 1, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            word(32'h1 << (i % 32), 0, 1, 1, 1, i);
            word(0, 0, 1, 0, 0, i);
        end
        word(32'h10, 1, 1, 1, 1, 0);
        word(32'h2, 0, 1, 1, 1, 1);

        // async reset in the middle of a cycle
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", ifc.locked, 0);
        chk("arst_count", ifc.err_count, 0);
        chk("arst_bits", ifc.err_bits, 0);
        chk("arst_locked4", ifc4.locked, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // random valid gaps on a clean stream
        vcnt = 0;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                vcnt++;
                word(0, 0, vcnt >= 5, 0, (vcnt == 1) ? -1 : 0, 0);
            end else begin
                idle();
            end
        end
        idle();
        idle();
        chk("gap_locked", ifc.locked, (vcnt >= 5) ? 1 : 0);
        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
